// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches the word at the current PC over a req/gnt/rvalid port, then strobes PC+4 back to the PC register.
// Optional FETCH_UNIT_TIMEOUT_EN adds a REQ/WAIT watchdog that faults with cause 10 after TIMEOUT_CYCLES.
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_srst,
  input  logic [31:0] i_pc,
  input  logic        i_fetchStart,
  input  logic        i_faultClr,
  output logic        o_memReq,
  output logic [31:0] o_memAddr,
  input  logic        i_memGnt,
  input  logic        i_memRvalid,
  input  logic [31:0] i_memRdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_oldPc,
  output logic [31:0] o_pcPlus4,
  output logic        o_pcWrite,
  output logic        o_instrValid,
  output logic        o_busy,
  output logic        o_fault,
  output logic [1:0]  o_faultCause
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] INSTR_BYTES  = 32'd4;
  localparam logic [1:0]      CAUSE_NONE   = 2'b00;
  localparam logic [1:0]      CAUSE_MISAL  = 2'b01;
  localparam logic [1:0]      CAUSE_TMO    = 2'b10;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYCLES must be in 2..255");
  end

  // S_RESP holds the captured read data for one cycle before it is published.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            pc_write_q, pc_write_d;
  logic            instr_valid_q, instr_valid_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;
  logic [1:0]      cause_q, cause_d;

`ifdef FETCH_UNIT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rdata_d       = rdata_q;
    mem_req_d     = 1'b0;
    instr_d       = instr_q;
    old_pc_d      = old_pc_q;
    pc_plus4_d    = pc_plus4_q;
    pc_write_d    = 1'b0;
    instr_valid_d = 1'b0;
    busy_d        = 1'b0;
    fault_d       = fault_q;
    cause_d       = cause_q;
`ifdef FETCH_UNIT_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_fetchStart) begin
          if (i_pc[1:0] == 2'b00) begin
            state_d   = S_REQ;
            addr_d    = i_pc;
            mem_req_d = 1'b1;
            busy_d    = 1'b1;
`ifdef FETCH_UNIT_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_MISAL;
          end
        end
      end

      S_REQ: begin
        busy_d = 1'b1;
        if (i_memGnt) begin
          state_d = S_WAIT;
        end else begin
          mem_req_d = 1'b1;
        end
`ifdef FETCH_UNIT_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        if (tmo_cnt_d == TMO_LIMIT) begin
          state_d   = S_FAULT;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          fault_d   = 1'b1;
          cause_d   = CAUSE_TMO;
        end
`endif
      end

      S_WAIT: begin
        busy_d = 1'b1;
        // A response in the same cycle the watchdog expires still completes.
        if (i_memRvalid) begin
          state_d = S_RESP;
          rdata_d = i_memRdata;
        end
`ifdef FETCH_UNIT_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          if (tmo_cnt_d == TMO_LIMIT) begin
            state_d = S_FAULT;
            busy_d  = 1'b0;
            fault_d = 1'b1;
            cause_d = CAUSE_TMO;
          end
        end
`endif
      end

      S_RESP: begin
        state_d       = S_IDLE;
        instr_d       = rdata_q;
        old_pc_d      = addr_q;
        pc_plus4_d    = addr_q + INSTR_BYTES;
        pc_write_d    = 1'b1;
        instr_valid_d = 1'b1;
      end

      S_FAULT: begin
        if (i_faultClr) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      rdata_q       <= '0;
      mem_req_q     <= 1'b0;
      instr_q       <= NOP_INSTR;
      old_pc_q      <= '0;
      pc_plus4_q    <= '0;
      pc_write_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
      cause_q       <= CAUSE_NONE;
`ifdef FETCH_UNIT_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rdata_q       <= rdata_d;
      mem_req_q     <= mem_req_d;
      instr_q       <= instr_d;
      old_pc_q      <= old_pc_d;
      pc_plus4_q    <= pc_plus4_d;
      pc_write_q    <= pc_write_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
      cause_q       <= cause_d;
`ifdef FETCH_UNIT_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign o_memReq     = mem_req_q;
  assign o_memAddr    = addr_q;
  assign o_instr      = instr_q;
  assign o_oldPc      = old_pc_q;
  assign o_pcPlus4    = pc_plus4_q;
  assign o_pcWrite    = pc_write_q;
  assign o_instrValid = instr_valid_q;
  assign o_busy       = busy_q;
  assign o_fault      = fault_q;
  assign o_faultCause = cause_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer side of the program counter in the multi-cycle core.
- Takes the current PC value and fetches the 32-bit instruction over a request/grant/response memory port.
- Latches the instruction into the instruction register and returns PC+4 to the PC register, with a one-cycle load strobe.
- Sits between the pc register, the instruction memory and the main control FSM's fetch step.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in REQ+WAIT before a timeout fault (used only with FETCH_UNIT_TIMEOUT_EN); legal range 2..255.

Ports:
- i_clk  input  1  clock.
- i_srst  input  1  synchronous active-high reset.
- i_pc  input  32  current PC from the pc register.
- i_fetchStart  input  1  controller requests one fetch; sampled only in IDLE.
- i_faultClr  input  1  clears a sticky fault; returns to IDLE.
- o_memReq  output  1  memory request.
- o_memAddr  output  32  fetch address; stable while o_memReq=1.
- i_memGnt  input  1  memory accepts the request.
- i_memRvalid  input  1  read data valid.
- i_memRdata  input  32  read data.
- o_instr  output  32  instruction register.
- o_oldPc  output  32  address of the instruction in o_instr.
- o_pcPlus4  output  32  o_oldPc + 4; drives the pc register's next-PC input.
- o_pcWrite  output  1  one-cycle strobe loading o_pcPlus4 into the PC.
- o_instrValid  output  1  one-cycle strobe: o_instr updated this cycle.
- o_busy  output  1  high in REQ or WAIT.
- o_fault  output  1  sticky fault flag.
- o_faultCause  output  2  00 none, 01 misaligned PC, 10 timeout.

Behaviour:
- One clock, i_clk. Reset is synchronous, active-high, on i_srst. All outputs are registered.
- Reset values:
  - o_memReq=0, o_memAddr=0.
  - o_instr=0x00000013 (NOP).
  - o_oldPc=0, o_pcPlus4=0.
  - o_pcWrite=0, o_instrValid=0, o_busy=0.
  - o_fault=0, o_faultCause=00.
  - State=IDLE, timeout count=0.
- IDLE:
  - i_fetchStart=1 and i_pc[1:0]==00: latch i_pc into address register, go to REQ.
  - i_fetchStart=1 and i_pc[1:0]!=00: go to FAULT with cause 01. No memory request is issued.
- REQ:
  - o_memReq=1, o_memAddr=latched address.
  - i_memGnt=1 sampled: next state WAIT, o_memReq drops next cycle.
  - i_memRvalid is ignored in REQ; a response is legal at the earliest one cycle after grant.
- WAIT:
  - i_memRvalid=1 sampled: next cycle o_instr=i_memRdata, o_oldPc=address, o_pcPlus4=address+4 (mod 2^32; 0xFFFFFFFC -> 0x00000000).
  - o_pcWrite=1 and o_instrValid=1 for exactly that one cycle; state returns to IDLE.
- Best-case latency: start sampled at edge N; o_memReq high after N; grant sampled at N+1; rvalid sampled at N+2; strobes high after edge N+3.
- o_instr, o_oldPc and o_pcPlus4 hold between fetches.
- i_fetchStart outside IDLE is ignored; requests are neither queued nor counted.
- FAULT:
  - o_fault=1, cause held, o_memReq=0, no strobes.
  - i_fetchStart ignored.
  - i_faultClr=1: next cycle IDLE, o_fault=0, cause=00.
- i_faultClr outside FAULT has no effect.
- i_srst mid-operation: next cycle IDLE with reset values. A stale i_memRvalid arriving afterwards is ignored in IDLE.
- i_srst has priority over every other input.

Optional Feature:
- Macro: FETCH_UNIT_TIMEOUT_EN.
- Defined:
  - 8-bit counter cleared on IDLE->REQ, incremented each cycle in REQ or WAIT.
  - If it reaches TIMEOUT_CYCLES before rvalid is sampled: go to FAULT, cause 10, o_memReq drops.
  - rvalid sampled in the same cycle the count reaches the limit wins; the fetch completes normally.
- Undefined: no counter; REQ/WAIT wait indefinitely; cause 10 is never produced.

Test Plan:
- Reset, then idle 3 cycles -> o_instr=0x00000013, every other output 0, o_memReq never asserted.
- i_pc=0x00000100, start; grant in the first REQ cycle; rvalid next cycle with rdata=0x00500093 -> o_instr=0x00500093, o_oldPc=0x100, o_pcPlus4=0x104, o_pcWrite high for exactly 1 cycle, 3 cycles after the start was sampled.
- i_pc=0xFFFFFFFC, grant withheld 4 cycles then given, rvalid 2 cycles later -> o_memAddr stable throughout REQ, o_pcPlus4=0x00000000; i_fetchStart pulses while busy produce no extra fetch.
- i_pc=0x00000102, start -> o_memReq stays 0, o_fault=1, cause=01 persists through further starts; i_faultClr -> IDLE, then a fetch at 0x104 completes normally.
- With FETCH_UNIT_TIMEOUT_EN and TIMEOUT_CYCLES=16: grant given, rvalid never arrives -> cause=10 after 16 busy cycles; a late rvalid afterwards is ignored. Same stimulus with the macro undefined -> still busy after 100 cycles, no fault.
- i_srst asserted in WAIT, then rvalid=1 the following cycle -> IDLE with reset values, no o_pcWrite, o_instr stays 0x00000013.
